// File: rtl/note_slot_scheduler.sv
// note_slot_scheduler
//   Takes note events (code + octave) over a valid/ready handshake and queues
//   them in a 4-deep FIFO. Each event is placed in the next slot of an
//   on-screen history grid. The renderer is driven through a start/done
//   handshake. When the write pointer lands on an occupied slot, the old
//   glyph is erased before the new one is drawn.
//
// Ports
//   clk, reset            system clock, synchronous active-low reset
//   note_valid/note_ready upstream handshake; note_in (1..12 legal), octave_in
//   clear_req             pulse: forget history and flush queued events
//   draw_start/draw_done  renderer handshake (one-cycle pulses)
//   note, octave, x, y    glyph to render and slot origin (held until done)
//   erase                 1 = draw in background colour
//   busy                  FSM not idle
//   drop_count            saturating count of rejected illegal note codes
module note_slot_scheduler #(
    parameter int SLOTS  = 8,
    parameter int COLS   = 4,
    parameter int X0     = 4,
    parameter int Y0     = 8,
    parameter int CELL_W = 38,
    parameter int CELL_H = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       note_valid,
    input  logic [3:0] note_in,
    input  logic [1:0] octave_in,
    output logic       note_ready,
    input  logic       clear_req,
    output logic       draw_start,
    input  logic       draw_done,
    output logic [3:0] note,
    output logic [1:0] octave,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       erase,
    output logic       busy,
    output logic [7:0] drop_count
);

    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_ERASE_WAIT,
        ST_DRAW,
        ST_DRAW_WAIT
    } state_t;

    state_t          state_q, state_d;

    logic [5:0]      fifo_mem_q [4];
    logic [5:0]      fifo_mem_d [4];
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [2:0]      count_q, count_d;

    logic [3:0]      hold_note_q, hold_note_d;
    logic [1:0]      hold_oct_q, hold_oct_d;

    logic [3:0]      slot_note_q [SLOTS];
    logic [3:0]      slot_note_d [SLOTS];
    logic [1:0]      slot_oct_q [SLOTS];
    logic [1:0]      slot_oct_d [SLOTS];
    logic [SLOTS-1:0] slot_valid_q, slot_valid_d;
    logic [SW-1:0]   wr_slot_q, wr_slot_d;
    logic            clear_pend_q, clear_pend_d;

    logic            draw_start_q, draw_start_d;
    logic            erase_q, erase_d;
    logic [3:0]      note_q, note_d;
    logic [1:0]      octave_q, octave_d;
    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic [7:0]      drop_q, drop_d;

    logic            accept;
    logic            legal;
    logic            push;
    logic            pop;
    logic            flush;
    logic [5:0]      fifo_head;
    logic [9:0]      pos_x;
    logic [9:0]      pos_y;

    // Slot origin, computed wide and truncated to the output widths.
    assign pos_x = 10'(X0 + (32'(wr_slot_q) % COLS) * CELL_W);
    assign pos_y = 10'(Y0 + (32'(wr_slot_q) / COLS) * CELL_H);

    assign note_ready = (count_q != 3'd4) && reset;
    assign accept     = note_valid && note_ready;
    assign legal      = (note_in >= 4'd1) && (note_in <= 4'd12);
    assign push       = accept && legal;
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        fifo_mem_d   = fifo_mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        hold_note_d  = hold_note_q;
        hold_oct_d   = hold_oct_q;
        slot_note_d  = slot_note_q;
        slot_oct_d   = slot_oct_q;
        slot_valid_d = slot_valid_q;
        wr_slot_d    = wr_slot_q;
        clear_pend_d = clear_pend_q;
        draw_start_d = 1'b0;
        erase_d      = erase_q;
        note_d       = note_q;
        octave_d     = octave_q;
        x_d          = x_q;
        y_d          = y_q;
        drop_d       = drop_q;
        pop          = 1'b0;
        flush        = 1'b0;

        if (accept && !legal && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (clear_pend_q) begin
                    flush        = 1'b1;
                    slot_valid_d = '0;
                    wr_slot_d    = '0;
                    clear_pend_d = 1'b0;
                end else if (count_q != 3'd0) begin
                    pop          = 1'b1;
                    hold_note_d  = fifo_head[5:2];
                    hold_oct_d   = fifo_head[1:0];
                    x_d          = pos_x[7:0];
                    y_d          = pos_y[6:0];
                    draw_start_d = 1'b1;
                    if (slot_valid_q[wr_slot_q]) begin
                        erase_d  = 1'b1;
                        note_d   = slot_note_q[wr_slot_q];
                        octave_d = slot_oct_q[wr_slot_q];
                        state_d  = ST_ERASE;
                    end else begin
                        erase_d  = 1'b0;
                        note_d   = fifo_head[5:2];
                        octave_d = fifo_head[1:0];
                        state_d  = ST_DRAW;
                    end
                end
            end
            ST_ERASE: state_d = ST_ERASE_WAIT;
            ST_ERASE_WAIT: begin
                if (draw_done) begin
                    draw_start_d = 1'b1;
                    erase_d      = 1'b0;
                    note_d       = hold_note_q;
                    octave_d     = hold_oct_q;
                    state_d      = ST_DRAW;
                end
            end
            ST_DRAW: state_d = ST_DRAW_WAIT;
            ST_DRAW_WAIT: begin
                if (draw_done) begin
                    slot_note_d[wr_slot_q]  = hold_note_q;
                    slot_oct_d[wr_slot_q]   = hold_oct_q;
                    slot_valid_d[wr_slot_q] = 1'b1;
                    wr_slot_d = (wr_slot_q == SW'(SLOTS - 1)) ? '0 : wr_slot_q + SW'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new request always wins over the one being serviced this cycle.
        if (clear_req) begin
            clear_pend_d = 1'b1;
        end

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_mem_d[wr_ptr_q] = {note_in, octave_in};
                wr_ptr_d = wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            fifo_mem_q   <= '{default: '0};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            hold_note_q  <= '0;
            hold_oct_q   <= '0;
            slot_note_q  <= '{default: '0};
            slot_oct_q   <= '{default: '0};
            slot_valid_q <= '0;
            wr_slot_q    <= '0;
            clear_pend_q <= 1'b0;
            draw_start_q <= 1'b0;
            erase_q      <= 1'b0;
            note_q       <= '0;
            octave_q     <= '0;
            x_q          <= 8'(X0);
            y_q          <= 7'(Y0);
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            fifo_mem_q   <= fifo_mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            hold_note_q  <= hold_note_d;
            hold_oct_q   <= hold_oct_d;
            slot_note_q  <= slot_note_d;
            slot_oct_q   <= slot_oct_d;
            slot_valid_q <= slot_valid_d;
            wr_slot_q    <= wr_slot_d;
            clear_pend_q <= clear_pend_d;
            draw_start_q <= draw_start_d;
            erase_q      <= erase_d;
            note_q       <= note_d;
            octave_q     <= octave_d;
            x_q          <= x_d;
            y_q          <= y_d;
            drop_q       <= drop_d;
        end
    end

    assign draw_start = draw_start_q;
    assign erase      = erase_q;
    assign note       = note_q;
    assign octave     = octave_q;
    assign x          = x_q;
    assign y          = y_q;
    assign busy       = (state_q != ST_IDLE);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_note_slot_scheduler.sv
// tb_note_slot_scheduler
//   Self-checking bench for note_slot_scheduler. A reference model turns each
//   accepted legal event into the expected renderer pulses (erase of the old
//   slot contents when occupied, then the draw). A renderer model answers
//   draw_start with draw_done after a fixed or random delay and checks every
//   pulse against the model.
module tb_note_slot_scheduler;

    localparam int SLOTS  = 8;
    localparam int COLS   = 4;
    localparam int X0     = 4;
    localparam int Y0     = 8;
    localparam int CELL_W = 38;
    localparam int CELL_H = 16;

    logic       clk;
    logic       reset;
    logic       note_valid;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       note_ready;
    logic       clear_req;
    logic       draw_start;
    logic       draw_done;
    logic [3:0] note;
    logic [1:0] octave;
    logic [7:0] x;
    logic [6:0] y;
    logic       erase;
    logic       busy;
    logic [7:0] drop_count;

    note_slot_scheduler #(
        .SLOTS (SLOTS),
        .COLS  (COLS),
        .X0    (X0),
        .Y0    (Y0),
        .CELL_W(CELL_W),
        .CELL_H(CELL_H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .note_valid(note_valid),
        .note_in   (note_in),
        .octave_in (octave_in),
        .note_ready(note_ready),
        .clear_req (clear_req),
        .draw_start(draw_start),
        .draw_done (draw_done),
        .note      (note),
        .octave    (octave),
        .x         (x),
        .y         (y),
        .erase     (erase),
        .busy      (busy),
        .drop_count(drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic er;
        int   n;
        int   o;
        int   px;
        int   py;
    } pulse_t;

    pulse_t exp_q[$];
    int     obs_x[$];
    int     obs_y[$];
    int     obs_n[$];
    int     obs_o[$];
    int     obs_e[$];

    bit     m_valid [SLOTS];
    int     m_note  [SLOTS];
    int     m_oct   [SLOTS];
    int     m_slot;
    int     m_drops;

    bit     rend_stall;
    int     rend_lat;
    bit     rend_pend;

    int     n3 [8] = '{3, 5, 7, 9, 12, 1, 2, 6};

    function automatic void model_clear();
        for (int i = 0; i < SLOTS; i++) m_valid[i] = 1'b0;
        m_slot = 0;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        model_clear();
        m_drops = 0;
    endfunction

    function automatic void model_accept(input int n, input int o);
        int px;
        int py;
        px = (X0 + (m_slot % COLS) * CELL_W) % 256;
        py = (Y0 + (m_slot / COLS) * CELL_H) % 128;
        if (m_valid[m_slot]) exp_q.push_back('{1'b1, m_note[m_slot], m_oct[m_slot], px, py});
        exp_q.push_back('{1'b0, n, o, px, py});
        m_valid[m_slot] = 1'b1;
        m_note[m_slot]  = n;
        m_oct[m_slot]   = o;
        m_slot = (m_slot + 1) % SLOTS;
    endfunction

    // ---------------- renderer + pulse monitor ----------------
    initial begin
        pulse_t      e;
        logic [21:0] cap;
        int          cnt;
        draw_done = 1'b0;
        rend_pend = 1'b0;
        cnt       = 0;
        cap       = '0;
        forever begin
            @(negedge clk);
            draw_done = 1'b0;
            if (!reset) begin
                rend_pend = 1'b0;
            end else if (draw_start) begin
                obs_x.push_back(int'(x));
                obs_y.push_back(int'(y));
                obs_n.push_back(int'(note));
                obs_o.push_back(int'(octave));
                obs_e.push_back(int'(erase));
                check_eq("pulse_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("pulse_erase", erase, e.er);
                    check_eq("pulse_note", note, e.n);
                    check_eq("pulse_octave", octave, e.o);
                    check_eq("pulse_x", x, e.px);
                    check_eq("pulse_y", y, e.py);
                end
                cap       = {note, octave, x, y, erase};
                rend_pend = 1'b1;
                cnt       = (rend_lat > 0) ? rend_lat : int'($urandom_range(1, 6));
            end else if (rend_pend && !rend_stall) begin
                if (cnt <= 1) begin
                    draw_done = 1'b1;
                    rend_pend = 1'b0;
                    check_eq("hold_at_done", {note, octave, x, y, erase}, cap);
                end else begin
                    cnt--;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input int n, input int o, input bit do_model, input int max_wait, output bit ok);
        note_in    = 4'(n);
        octave_in  = 2'(o);
        note_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (note_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            if (n >= 1 && n <= 12) begin
                if (do_model) model_accept(n, o);
            end else begin
                m_drops = (m_drops < 255) ? m_drops + 1 : 255;
            end
        end else begin
            @(posedge clk);
            #1;
        end
        note_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !rend_pend) break;
        end
        check_eq("drain_queue", exp_q.size(), 0);
        check_eq("drain_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b0;
        note_valid = 1'b0;
        clear_req  = 1'b0;
        rend_stall = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic int illegal_code();
        int c;
        c = int'($urandom_range(0, 3));
        return (c == 0) ? 0 : 12 + c;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        bit ok6;
        int acc;
        int base;
        int cnt_e;
        int nt;

        reset      = 1'b0;
        note_valid = 1'b0;
        note_in    = '0;
        octave_in  = '0;
        clear_req  = 1'b0;
        rend_stall = 1'b0;
        rend_lat   = 3;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_draw_start", draw_start, 0);
        check_eq("rst_erase", erase, 0);
        check_eq("rst_note", note, 0);
        check_eq("rst_octave", octave, 0);
        check_eq("rst_x", x, X0);
        check_eq("rst_y", y, Y0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_drop", drop_count, 0);
        check_eq("rst_ready", note_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", note_ready, 1);

        // First event latency
        @(posedge clk);
        #1;
        note_in = 4'd4; octave_in = 2'd2; note_valid = 1'b1;
        model_accept(4, 2);
        @(posedge clk);
        #1;
        note_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_start_early", draw_start, 0);
        @(negedge clk);
        check_eq("lat_start", draw_start, 1);
        check_eq("lat_note", note, 4);
        check_eq("lat_octave", octave, 2);
        check_eq("lat_x", x, 4);
        check_eq("lat_y", y, 8);
        check_eq("lat_erase", erase, 0);
        @(posedge clk);
        #1;
        wait_drain(100);

        // Eight events fill the grid
        apply_reset();
        rend_lat = 5;
        base = obs_x.size();
        for (int i = 0; i < 8; i++) begin
            send(n3[i], i % 4, 1'b1, 100, ok);
            check_eq("fill_accept", ok, 1);
        end
        wait_drain(500);
        check_eq("fill_pulses", obs_x.size() - base, 8);
        if (obs_x.size() >= base + 8) begin
            check_eq("slot5_x", obs_x[base + 5], 42);
            check_eq("slot5_y", obs_y[base + 5], 24);
            check_eq("slot7_x", obs_x[base + 7], 118);
            check_eq("slot7_y", obs_y[base + 7], 24);
            cnt_e = 0;
            for (int i = 0; i < 8; i++) cnt_e += obs_e[base + i];
            check_eq("fill_no_erase", cnt_e, 0);
        end

        // Ninth event wraps onto slot 0
        base = obs_x.size();
        send(11, 3, 1'b1, 100, ok);
        wait_drain(200);
        check_eq("wrap_pulses", obs_x.size() - base, 2);
        if (obs_x.size() >= base + 2) begin
            check_eq("wrap_er_flag", obs_e[base], 1);
            check_eq("wrap_er_note", obs_n[base], n3[0]);
            check_eq("wrap_er_oct", obs_o[base], 0);
            check_eq("wrap_er_x", obs_x[base], 4);
            check_eq("wrap_er_y", obs_y[base], 8);
            check_eq("wrap_dr_flag", obs_e[base + 1], 0);
            check_eq("wrap_dr_note", obs_n[base + 1], 11);
            check_eq("wrap_dr_oct", obs_o[base + 1], 3);
        end

        // Reset in the middle of a draw abandons it
        apply_reset();
        rend_stall = 1'b1;
        base = obs_x.size();
        send(7, 1, 1'b1, 20, ok);
        repeat (4) begin @(posedge clk); #1; end
        check_eq("mid_pulse", obs_x.size() - base, 1);
        base = obs_x.size();
        apply_reset();
        repeat (10) begin @(posedge clk); #1; end
        check_eq("mid_no_pulse", obs_x.size() - base, 0);
        check_eq("mid_busy", busy, 0);

        // Stalled renderer: hold register + 4 FIFO entries
        apply_reset();
        rend_stall = 1'b1;
        rend_lat   = 2;
        base = obs_x.size();
        acc  = 0;
        for (int i = 0; i < 5; i++) begin
            send(i + 1, i % 4, 1'b1, 3, ok);
            acc += int'(ok);
        end
        send(10, 2, 1'b1, 6, ok6);
        check_eq("stall_accepts", acc, 5);
        check_eq("stall_6th_rejected", ok6, 0);
        @(negedge clk);
        check_eq("stall_ready", note_ready, 0);
        check_eq("stall_busy", busy, 1);
        @(posedge clk);
        #1;
        rend_stall = 1'b0;
        wait_drain(300);
        check_eq("stall_pulses", obs_x.size() - base, 5);

        // Illegal codes
        apply_reset();
        base = obs_x.size();
        send(0, 1, 1'b1, 5, ok);
        send(13, 2, 1'b1, 5, ok);
        send(15, 3, 1'b1, 5, ok);
        repeat (5) begin @(posedge clk); #1; end
        check_eq("drop_three", drop_count, 3);
        check_eq("drop_no_pulse", obs_x.size() - base, 0);
        for (int i = 0; i < 300; i++) send(illegal_code(), 0, 1'b1, 5, ok);
        @(negedge clk);
        check_eq("drop_saturate", drop_count, 255);
        @(posedge clk);
        #1;

        // clear_req during DRAW_WAIT with two events queued
        apply_reset();
        rend_stall = 1'b1;
        rend_lat   = 2;
        send(5, 1, 1'b1, 5, ok);
        send(6, 2, 1'b0, 5, ok);
        send(8, 3, 1'b0, 5, ok);
        repeat (3) begin @(posedge clk); #1; end
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        model_clear();
        @(negedge clk);
        check_eq("clr_draw_kept", busy, 1);
        @(posedge clk);
        #1;
        rend_stall = 1'b0;
        wait_drain(100);
        base = obs_x.size();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("clr_idle_busy", busy, 0);
        end
        check_eq("clr_flushed", obs_x.size() - base, 0);
        check_eq("clr_ready", note_ready, 1);
        @(posedge clk);
        #1;
        send(9, 0, 1'b1, 5, ok);
        wait_drain(100);
        check_eq("clr_next_pulses", obs_x.size() - base, 1);
        if (obs_x.size() > base) begin
            check_eq("clr_next_x", obs_x[base], 4);
            check_eq("clr_next_y", obs_y[base], 8);
            check_eq("clr_next_erase", obs_e[base], 0);
            check_eq("clr_next_note", obs_n[base], 9);
        end

        // Randomized traffic against the model
        apply_reset();
        rend_lat = 0;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            nt = ($urandom_range(0, 7) == 0) ? illegal_code() : int'($urandom_range(1, 12));
            send(nt, int'($urandom_range(0, 3)), 1'b1, 200, ok);
            check_eq("rand_accept", ok, 1);
        end
        wait_drain(3000);
        check_eq("rand_drops", drop_count, m_drops);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_slot_scheduler.md
# note_slot_scheduler

Upstream stage of the glyph renderer. Accepts note events (note code + octave) from the pitch-detection side through a valid/ready handshake and buffers them in a 4-deep FIFO. It assigns each event to the next slot of an on-screen history grid, and drives the renderer with position, codes and an erase flag through a start/done handshake. When the pointer wraps onto an occupied slot, it erases the old glyph before drawing the new one.

## Interface
Parameters:
- SLOTS, 8, number of history slots (power of two, ≤16)
- COLS, 4, slots per grid row
- X0, 4, x pixel of slot 0
- Y0, 8, y pixel of slot 0
- CELL_W, 38, horizontal slot pitch in pixels (3 glyphs × 12 + 2 gap)
- CELL_H, 16, vertical slot pitch in pixels

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- note_valid  in  1  upstream event valid
- note_in  in  4  note code, legal 1..12
- octave_in  in  2  octave 0..3
- note_ready  out  1  event accepted when note_valid && note_ready
- clear_req  in  1  pulse: forget history, flush FIFO
- draw_start  out  1  one-cycle pulse to renderer
- draw_done  in  1  one-cycle pulse from renderer, glyph finished
- note  out  4  code to render
- octave  out  2  octave to render
- x  out  8  slot x origin
- y  out  7  slot y origin
- erase  out  1  1 = renderer draws in background colour
- busy  out  1  FSM not in IDLE
- drop_count  out  8  saturating count of rejected illegal note codes

## Operation
- Input filter: an accepted event with note_in of 0 or 13..15 is discarded, not written, and drop_count increments (saturates at 255). octave_in is never filtered.
- FIFO: 4 entries × 6 bits. note_ready = !full && reset. No push-while-full bypass: when full, ready stays 0 even in a pop cycle.
- Slot table: per slot a valid bit plus the stored 4-bit note and 2-bit octave. wr_slot pointer, width log2(SLOTS), wraps SLOTS-1 → 0.
- Position: col = wr_slot % COLS, row = wr_slot / COLS. x = X0 + col*CELL_W and y = Y0 + row*CELL_H, computed at 10 bits and truncated to 8 and 7 bits respectively.
- FSM states and transitions:
  - IDLE:
    - If clear_pend is set: clear all valid bits, reset wr_slot to 0, empty the FIFO, clear clear_pend; stay in IDLE.
    - Otherwise, if the FIFO is non-empty: pop into a holding register. Go to ERASE if the slot is valid, else to DRAW.
  - ERASE: draw_start=1, erase=1, note/octave = stored slot contents → ERASE_WAIT.
  - ERASE_WAIT: on draw_done → DRAW.
  - DRAW: draw_start=1, erase=0, note/octave = held event → DRAW_WAIT.
  - DRAW_WAIT: on draw_done, write the slot table entry, set its valid bit, advance wr_slot → IDLE.
- clear_req sets clear_pend in any state. It never aborts a draw in progress; it is serviced on the next IDLE cycle ahead of FIFO pops.
- draw_done is ignored outside the *_WAIT states.
- note, octave, x, y and erase are registered and held stable from the draw_start cycle until the draw_done cycle inclusive.

## Timing
- Reset, while reset=0 at a clk edge:
  - FSM → IDLE; FIFO emptied; wr_slot=0; all valid bits cleared; clear_pend=0.
  - Outputs: draw_start=0, erase=0, note=0, octave=0, x=X0, y=Y0, busy=0, drop_count=0, note_ready=0.
- Reset mid-draw abandons the draw. No draw_start is issued until a new event arrives.
- Latency: event accepted at edge k → popped at edge k+1 → draw_start high in the cycle after edge k+1, i.e. 2 cycles, when the slot is free. An occupied slot adds an erase round trip (draw_start … draw_done) before the DRAW pulse.
- Minimum spacing: DRAW_WAIT → IDLE → next pop gives ≥2 cycles between consecutive draw_start pulses.
- A push and a pop in the same cycle leave the FIFO count unchanged.
- draw_done arriving in the same cycle as draw_start is not honoured, because the FSM is not yet in a WAIT state.

## Test plan
- Reset → all outputs at reset values, note_ready=1 one cycle after reset=1. Push (note 4, oct 2) → draw_start 2 cycles later with note=4, octave=2, x=4, y=8, erase=0.
- 8 legal events, renderer done after 5 cycles each → slots 0..7 drawn. Slot 5 must read x=42, y=24; slot 7 must read x=118, y=24; no erase pulses.
- 9th event (note 11, oct 3) after the above → an ERASE pulse for slot 0 with the old note, octave, x=4, y=8, erase=1, then a DRAW pulse with note=11, octave=3.
- Renderer stalled (no draw_done) while 6 events are offered → 1 in the holding register plus 4 in the FIFO; note_ready drops to 0 after the 5th accept. On release, all 5 are drawn in order.
- Push note codes 0, 13 and 15 → no draw_start, drop_count=3. Drive 300 illegal codes → drop_count=255.
- clear_req mid-DRAW_WAIT with 2 events queued → the current draw completes and the slot table write happens. Then the valid bits clear, the FIFO is flushed, the next event draws at slot 0 with erase=0, and busy=0 in between.
